// File: rtl/ccd_frame_capture.sv
// ccd_frame_capture: samples the sensor Bayer pixel bus under FVAL/LVAL, gates
// capture to whole frames under start/stop control, and produces the pixel
// stream with column/row coordinates, a completed-frame count and a short-line flag.
module ccd_frame_capture #(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned COORD_W      = 11,
    parameter int unsigned COLUMN_WIDTH = 1280,
    parameter int unsigned ROW_HEIGHT   = 960
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [DATA_W-1:0]  iDATA,
    input  logic               iFVAL,
    input  logic               iLVAL,
    input  logic               iSTART,
    input  logic               iEND,
    output logic [DATA_W-1:0]  oDATA,
    output logic               oDVAL,
    output logic [COORD_W-1:0] oX_Cont,
    output logic [COORD_W-1:0] oY_Cont,
    output logic [31:0]        oFrame_Cont,
    output logic               oLine_Err
);

    localparam logic [COORD_W-1:0] XLast = COORD_W'(COLUMN_WIDTH - 1);
    localparam logic [COORD_W-1:0] YLast = COORD_W'(ROW_HEIGHT - 1);

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } state_e;

    state_e              state_q, state_d;
    logic                run_q, run_d;
    logic                fval_q, lval_q;
    logic [DATA_W-1:0]   data_q;
    logic [COORD_W-1:0]  x_q, x_d;
    logic [COORD_W-1:0]  y_q, y_d;
    logic [COORD_W-1:0]  y_inc;
    logic [31:0]         frame_cnt_q, frame_cnt_d;
    logic                line_err_q, line_err_d;
    logic                frame_done;
    logic                dval;
    logic                line_end;

    // Sensor strobes and pixel are registered once; everything downstream uses these.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fval_q <= 1'b0;
            lval_q <= 1'b0;
            data_q <= '0;
        end else begin
            fval_q <= iFVAL;
            lval_q <= iLVAL;
            data_q <= iDATA;
        end
    end

    // Run flag: stop has priority over start when both pulse together.
    always_comb begin
        run_d = run_q;
        if (iEND) begin
            run_d = 1'b0;
        end else if (iSTART) begin
            run_d = 1'b1;
        end
    end

    // Frame FSM next state: enter only on an armed FVAL rising edge, leave on any falling edge.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (iFVAL && !fval_q && run_q) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (!iFVAL && fval_q) begin
                    state_d    = StIdle;
                    frame_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dval     = (state_q == StActive) && lval_q;
    // Line ends at this edge: the last pixel of the line is currently on the output.
    assign line_end = lval_q && !iLVAL;
    assign y_inc    = (y_q == YLast) ? y_q : y_q + COORD_W'(1);

    // Coordinate tracking of the pixel on oDATA, including short-line recovery.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        line_err_d = 1'b0;
        if (state_q == StIdle) begin
            x_d = '0;
            y_d = '0;
        end else if (dval) begin
            if (x_q == XLast) begin
                x_d = '0;
                y_d = y_inc;
            end else if (line_end) begin
                // Line stopped before reaching the last column: resync to the next row.
                x_d        = '0;
                y_d        = y_inc;
                line_err_d = 1'b1;
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    // Completed-frame counter, wraps naturally at 2^32.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_done) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    // State, run flag, coordinates, counter and error pulse registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= StIdle;
            run_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            line_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            line_err_q  <= line_err_d;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFrame_Cont = frame_cnt_q;
    assign oLine_Err   = line_err_q;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Bench for ccd_frame_capture with a 4x3 frame geometry: a hand-computed vector
// table, directed multi-cycle sequences, and random stimulus against a pixel-level model.
module tb_ccd_frame_capture;

    localparam int DW = 12;
    localparam int CW = 11;
    localparam int COLS = 4;
    localparam int ROWS = 3;

    logic          clk;
    logic          iRST, iFVAL, iLVAL, iSTART, iEND;
    logic [DW-1:0] iDATA;
    logic [DW-1:0] oDATA;
    logic          oDVAL;
    logic [CW-1:0] oX_Cont, oY_Cont;
    logic [31:0]   oFrame_Cont;
    logic          oLine_Err;

    ccd_frame_capture #(
        .DATA_W      (DW),
        .COORD_W     (CW),
        .COLUMN_WIDTH(COLS),
        .ROW_HEIGHT  (ROWS)
    ) dut (
        .iCLK       (clk),
        .iRST       (iRST),
        .iDATA      (iDATA),
        .iFVAL      (iFVAL),
        .iLVAL      (iLVAL),
        .iSTART     (iSTART),
        .iEND       (iEND),
        .oDATA      (oDATA),
        .oDVAL      (oDVAL),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFrame_Cont(oFrame_Cont),
        .oLine_Err  (oLine_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Pixel-level reference model: each input pixel taken inside an armed frame is
    // given the next free (column,row) slot and reappears one cycle later.
    bit          m_run, m_cap, m_fprev, m_lprev;
    int          m_nx, m_ny;
    int unsigned m_frames;
    logic [DW-1:0] m_data;
    bit          m_dval, m_err;
    int          m_x, m_y;

    function automatic int next_row(input int r);
        return (r + 1 > ROWS - 1) ? ROWS - 1 : r + 1;
    endfunction

    task automatic model_step(input bit rst, input bit start, input bit stop, input bit fval,
                              input bit lval, input logic [DW-1:0] data);
        bit cap_next;
        if (rst) begin
            m_run = 0; m_cap = 0; m_fprev = 0; m_lprev = 0;
            m_nx = 0; m_ny = 0; m_frames = 0; m_data = '0;
            m_dval = 0; m_err = 0; m_x = 0; m_y = 0;
            return;
        end
        m_err  = 0;
        m_data = data;
        // A captured line that ended off a row boundary forces a new row.
        if (m_cap && m_lprev && !lval && m_nx != 0) begin
            m_err = 1;
            m_nx  = 0;
            m_ny  = next_row(m_ny);
        end
        cap_next = m_cap;
        if (!m_cap && fval && !m_fprev && m_run) begin
            cap_next = 1; m_nx = 0; m_ny = 0;
        end
        if (m_cap && !fval && m_fprev) begin
            cap_next = 0; m_frames++;
        end
        m_cap  = cap_next;
        m_dval = m_cap && lval;
        if (m_dval) begin
            m_x = m_nx;
            m_y = m_ny;
            m_nx++;
            if (m_nx == COLS) begin
                m_nx = 0;
                m_ny = next_row(m_ny);
            end
        end
        if (stop) m_run = 0;
        else if (start) m_run = 1;
        m_fprev = fval;
        m_lprev = lval;
    endtask

    task automatic compare_model();
        check("dval", 32'(oDVAL), 32'(m_dval));
        check("data", 32'(oDATA), 32'(m_data));
        check("frame_cnt", oFrame_Cont, m_frames);
        check("line_err", 32'(oLine_Err), 32'(m_err));
        if (m_dval) begin
            check("x", 32'(oX_Cont), 32'(m_x));
            check("y", 32'(oY_Cont), 32'(m_y));
        end
    endtask

    typedef struct {int x; int y; int d;} obs_t;
    obs_t obs[$];
    int   err_seen;

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input bit rst, input bit start, input bit stop, input bit fval,
                        input bit lval, input logic [DW-1:0] data, input bit use_model);
        @(negedge clk);
        iRST = rst; iSTART = start; iEND = stop; iFVAL = fval; iLVAL = lval; iDATA = data;
        @(posedge clk);
        model_step(rst, start, stop, fval, lval, data);
        #1;
        if (use_model) compare_model();
        if (oDVAL) obs.push_back('{int'(oX_Cont), int'(oY_Cont), int'(oDATA)});
        if (oLine_Err) err_seen++;
    endtask

    // Frame: first pixel coincides with FVAL rising, 2 gap cycles after each line.
    // Start/stop pulses go in the first gap cycle after line number start_after/end_after.
    task automatic send_frame(input int nlines, input int l0, input int l1, input int l2,
                              input int l3, input int base, input int start_after,
                              input int end_after);
        int lens[4];
        int idx;
        lens = '{l0, l1, l2, l3};
        idx  = 0;
        for (int li = 0; li < nlines; li++) begin
            for (int p = 0; p < lens[li]; p++) begin
                step(0, 0, 0, 1, 1, DW'(base + idx), 1);
                idx++;
            end
            step(0, li + 1 == start_after, li + 1 == end_after, 1, 0, DW'(base + idx), 1);
            step(0, 0, 0, 1, 0, '0, 1);
        end
        repeat (3) step(0, 0, 0, 0, 0, '0, 1);
    endtask

    typedef struct {
        bit rst; bit start; bit stop; bit fval; bit lval; logic [DW-1:0] data;
        bit e_dval; int e_x; int e_y; int e_cnt; bit e_err; logic [DW-1:0] e_data;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit start, input bit stop, input bit fval,
                                input bit lval, input logic [DW-1:0] data, input bit e_dval,
                                input int e_x, input int e_y, input int e_cnt, input bit e_err,
                                input logic [DW-1:0] e_data);
        vec_t v;
        v = '{rst, start, stop, fval, lval, data, e_dval, e_x, e_y, e_cnt, e_err, e_data};
        return v;
    endfunction

    vec_t vecs[21];
    int   frames_exp;

    initial begin
        iRST = 1; iSTART = 0; iEND = 0; iFVAL = 0; iLVAL = 0; iDATA = '0;

        // Reset, unarmed traffic, start+stop together, then a one-line frame with a short line.
        vecs[0]  = mk(1, 0, 0, 0, 0, 12'h0AB, 0, 0, 0, 0, 0, 12'h000);
        vecs[1]  = mk(0, 0, 0, 1, 0, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[2]  = mk(0, 0, 0, 1, 1, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[3]  = mk(0, 0, 0, 1, 1, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[4]  = mk(0, 0, 0, 0, 1, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[5]  = mk(0, 0, 0, 0, 0, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[6]  = mk(0, 0, 0, 1, 1, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[7]  = mk(0, 0, 0, 1, 0, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[8]  = mk(0, 0, 0, 1, 1, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[9]  = mk(0, 0, 0, 0, 0, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[10] = mk(0, 0, 0, 0, 0, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[11] = mk(0, 1, 1, 0, 0, 12'h0AB, 0, 0, 0, 0, 0, 12'h0AB);
        vecs[12] = mk(0, 0, 0, 1, 1, 12'h055, 0, 0, 0, 0, 0, 12'h055);
        vecs[13] = mk(0, 0, 0, 1, 1, 12'h056, 0, 0, 0, 0, 0, 12'h056);
        vecs[14] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 12'h000);
        vecs[15] = mk(0, 1, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 12'h000);
        vecs[16] = mk(0, 0, 0, 1, 1, 12'h200, 1, 0, 0, 0, 0, 12'h200);
        vecs[17] = mk(0, 0, 0, 1, 1, 12'h201, 1, 1, 0, 0, 0, 12'h201);
        vecs[18] = mk(0, 0, 0, 1, 0, 12'h000, 0, 0, 0, 0, 1, 12'h000);
        vecs[19] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1, 0, 12'h000);
        vecs[20] = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1, 0, 12'h000);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].fval, vecs[i].lval,
                 vecs[i].data, 0);
            check($sformatf("vec%0d_dval", i), 32'(oDVAL), 32'(vecs[i].e_dval));
            check($sformatf("vec%0d_data", i), 32'(oDATA), 32'(vecs[i].e_data));
            check($sformatf("vec%0d_cnt", i), oFrame_Cont, vecs[i].e_cnt);
            check($sformatf("vec%0d_err", i), 32'(oLine_Err), 32'(vecs[i].e_err));
            if (vecs[i].e_dval || i == 0) begin
                check($sformatf("vec%0d_x", i), 32'(oX_Cont), vecs[i].e_x);
                check($sformatf("vec%0d_y", i), 32'(oY_Cont), vecs[i].e_y);
            end
        end
        frames_exp = 1;

        // Full 4x3 frame, data 0x100+index.
        obs.delete(); err_seen = 0;
        send_frame(3, 4, 4, 4, 0, 'h100, 0, 0);
        frames_exp++;
        check("full_count", obs.size(), 12);
        foreach (obs[i]) begin
            check("full_x", obs[i].x, i % COLS);
            check("full_y", obs[i].y, i / COLS);
            check("full_data", obs[i].d, 'h100 + i);
        end
        check("full_no_err", err_seen, 0);
        check("full_frames", oFrame_Cont, frames_exp);

        // Disarm, then arm while FVAL is already high: that frame is skipped.
        step(0, 0, 1, 0, 0, '0, 1);
        obs.delete();
        send_frame(3, 4, 4, 4, 0, 'h400, 1, 0);
        check("late_start_none", obs.size(), 0);
        check("late_start_frames", oFrame_Cont, frames_exp);
        obs.delete();
        send_frame(3, 4, 4, 4, 0, 'h440, 0, 0);
        frames_exp++;
        check("after_late_count", obs.size(), 12);
        check("after_late_frames", oFrame_Cont, frames_exp);

        // Stop two lines in: the frame still completes; the next one is ignored.
        obs.delete();
        send_frame(3, 4, 4, 4, 0, 'h500, 0, 2);
        frames_exp++;
        check("stop_mid_count", obs.size(), 12);
        check("stop_mid_frames", oFrame_Cont, frames_exp);
        obs.delete();
        send_frame(3, 4, 4, 4, 0, 'h540, 0, 0);
        check("after_stop_none", obs.size(), 0);
        check("after_stop_frames", oFrame_Cont, frames_exp);

        // Short first line of 2 pixels.
        step(0, 1, 0, 0, 0, '0, 1);
        obs.delete(); err_seen = 0;
        send_frame(3, 2, 4, 4, 0, 'h600, 0, 0);
        frames_exp++;
        check("short_err_once", err_seen, 1);
        check("short_count", obs.size(), 10);
        if (obs.size() == 10) begin
            check("short_last_x", obs[1].x, 1);
            check("short_next_x", obs[2].x, 0);
            check("short_next_y", obs[2].y, 1);
            check("short_final_x", obs[9].x, 3);
            check("short_final_y", obs[9].y, 2);
        end
        check("short_frames", oFrame_Cont, frames_exp);

        // Reset mid-line at X=2.
        step(0, 0, 0, 1, 1, 'h300, 1);
        step(0, 0, 0, 1, 1, 'h301, 1);
        step(0, 0, 0, 1, 1, 'h302, 1);
        check("pre_rst_x", 32'(oX_Cont), 2);
        check("pre_rst_dval", 32'(oDVAL), 1);
        step(1, 0, 0, 1, 1, 'h303, 1);
        frames_exp = 0;
        check("rst_dval", 32'(oDVAL), 0);
        check("rst_data", 32'(oDATA), 0);
        check("rst_x", 32'(oX_Cont), 0);
        check("rst_y", 32'(oY_Cont), 0);
        check("rst_cnt", oFrame_Cont, 0);
        check("rst_err", 32'(oLine_Err), 0);
        obs.delete();
        step(0, 1, 0, 1, 1, 'h304, 1);
        step(0, 0, 0, 1, 1, 'h305, 1);
        step(0, 0, 0, 1, 0, '0, 1);
        step(0, 0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, 0, '0, 1);
        check("post_rst_idle", obs.size(), 0);
        check("post_rst_frames", oFrame_Cont, frames_exp);
        send_frame(3, 4, 4, 4, 0, 'h700, 0, 0);
        frames_exp++;
        check("rearm_count", obs.size(), 12);
        check("rearm_frames", oFrame_Cont, frames_exp);

        // Start and stop in the same cycle leave capture disarmed.
        step(0, 1, 1, 0, 0, '0, 1);
        obs.delete();
        send_frame(3, 4, 4, 4, 0, 'h780, 0, 0);
        check("both_none", obs.size(), 0);
        check("both_frames", oFrame_Cont, frames_exp);

        // Random frames with varied line lengths and start/stop placement.
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 2) != 0) step(0, 1, 0, 0, 0, DW'($urandom), 1);
            send_frame($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(1, 6),
                       $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(0, 4095),
                       $urandom_range(0, 3), $urandom_range(0, 5));
        end

        // Unstructured random bus activity, including occasional resets.
        begin
            bit fv;
            fv = 0;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 7) == 0) fv = !fv;
                step($urandom_range(0, 79) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 15) == 0, fv, $urandom_range(0, 1) == 1,
                     DW'($urandom), 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
